// File: rtl/conv_pkg.sv
// Shared types and defaults for the G.729 Convolve sequencer.
// Imported by conv_idx_gen and convolve_ctrl.
package conv_pkg;

  localparam int L_DEF      = 40;
  localparam int ADDR_W_DEF = 11;
  localparam int SHIFT_DEF  = 3;
  localparam int CNT_W      = 7;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD_X,
    RD_H,
    MAC,
    SHL,
    WR,
    FIN
  } state_t;

endpackage

// File: rtl/conv_idx_gen.sv
// n/i term counters, base-address latches and scratch address adders
// for the Convolve sequencer.
module conv_idx_gen
  import conv_pkg::*;
#(
  parameter int L      = L_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clrI_i,
  input  logic              incI_i,
  input  logic              incN_i,
  input  logic [ADDR_W-1:0] xAddr_i,
  input  logic [ADDR_W-1:0] hAddr_i,
  input  logic [ADDR_W-1:0] yAddr_i,
  output logic [ADDR_W-1:0] xRd_o,
  output logic [ADDR_W-1:0] hRd_o,
  output logic [ADDR_W-1:0] yWr_o,
  output logic              lastTerm_o,
  output logic              lastSample_o
);

  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic [ADDR_W-1:0] xB_q, xB_d;
  logic [ADDR_W-1:0] hB_q, hB_d;
  logic [ADDR_W-1:0] yB_q, yB_d;
  logic [CNT_W-1:0]  nMinusI;

  always_comb begin
    n_d  = n_q;
    i_d  = i_q;
    xB_d = xB_q;
    hB_d = hB_q;
    yB_d = yB_q;
    if (load_i) begin
      n_d  = '0;
      xB_d = xAddr_i;
      hB_d = hAddr_i;
      yB_d = yAddr_i;
    end
    if (incN_i) n_d = n_q + 1'b1;
    if (clrI_i) i_d = '0;
    if (incI_i) i_d = i_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q  <= '0;
      i_q  <= '0;
      xB_q <= '0;
      hB_q <= '0;
      yB_q <= '0;
    end else begin
      n_q  <= n_d;
      i_q  <= i_d;
      xB_q <= xB_d;
      hB_q <= hB_d;
      yB_q <= yB_d;
    end
  end

  // i never exceeds n, so the difference stays non-negative
  assign nMinusI      = n_q - i_q;
  assign xRd_o        = xB_q + ADDR_W'(i_q);
  assign hRd_o        = hB_q + ADDR_W'(nMinusI);
  assign yWr_o        = yB_q + ADDR_W'(n_q);
  assign lastTerm_o   = (i_q == n_q);
  assign lastSample_o = (n_q == CNT_W'(L - 1));

endmodule

// File: rtl/convolve_ctrl.sv
// Convolve sequencer: drives scratch memory, L_mac and L_shl.
// Optional cycleCount output enabled by CONV_CYCLE_CNT_EN.
module convolve_ctrl
  import conv_pkg::*;
#(
  parameter int L      = L_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] xAddr,
  input  logic [ADDR_W-1:0] hAddr,
  input  logic [ADDR_W-1:0] yAddr,
  input  logic [31:0]       memIn,
  input  logic [31:0]       L_macIn,
  input  logic [31:0]       L_shlIn,
  input  logic              L_shlDone,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic              memWriteEn,
  output logic [31:0]       memOut,
  output logic [15:0]       L_macOutA,
  output logic [15:0]       L_macOutB,
  output logic [31:0]       L_macOutC,
  output logic [31:0]       L_shlOutVar1,
  output logic [15:0]       L_shlNumShiftOut,
  output logic              L_shlReady,
  output logic              lagMuxSel,
  output logic              lagMux1Sel,
  output logic              busy,
  output logic              done
`ifdef CONV_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycleCount
`endif
);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] xReg_q, xReg_d;
  logic [15:0] yVal_q, yVal_d;
  logic        shlIss_q;

  logic              load, clrI, incI, incN;
  logic [ADDR_W-1:0] xRd, hRd, yWr;
  logic              lastTerm, lastSample;
  logic              unused_bits;

  assign unused_bits = ^{memIn[31:16], L_shlIn[15:0]};

  conv_idx_gen #(
    .L      (L),
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .clrI_i       (clrI),
    .incI_i       (incI),
    .incN_i       (incN),
    .xAddr_i      (xAddr),
    .hAddr_i      (hAddr),
    .yAddr_i      (yAddr),
    .xRd_o        (xRd),
    .hRd_o        (hRd),
    .yWr_o        (yWr),
    .lastTerm_o   (lastTerm),
    .lastSample_o (lastSample)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      xReg_q   <= '0;
      yVal_q   <= '0;
      shlIss_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      xReg_q   <= xReg_d;
      yVal_q   <= yVal_d;
      shlIss_q <= (state_q == SHL);
    end
  end

  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    xReg_d           = xReg_q;
    yVal_d           = yVal_q;
    load             = 1'b0;
    clrI             = 1'b0;
    incI             = 1'b0;
    incN             = 1'b0;
    memWriteAddr     = '0;
    memWriteEn       = 1'b0;
    memOut           = '0;
    L_macOutA        = '0;
    L_macOutB        = '0;
    L_macOutC        = '0;
    L_shlOutVar1     = '0;
    L_shlNumShiftOut = '0;
    L_shlReady       = 1'b0;
    lagMuxSel        = 1'b0;
    lagMux1Sel       = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy       = 1'b0;
        lagMuxSel  = 1'b1;
        lagMux1Sel = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = CLR;
        end
      end
      CLR: begin
        acc_d   = '0;
        clrI    = 1'b1;
        state_d = RD_X;
      end
      RD_X: begin
        memWriteAddr = xRd;
        state_d      = RD_H;
      end
      RD_H: begin
        memWriteAddr = hRd;
        xReg_d       = memIn[15:0];
        state_d      = MAC;
      end
      MAC: begin
        L_macOutA = xReg_q;
        L_macOutB = memIn[15:0];
        L_macOutC = acc_q;
        acc_d     = L_macIn;
        if (lastTerm) begin
          state_d = SHL;
        end else begin
          incI    = 1'b1;
          state_d = RD_X;
        end
      end
      SHL: begin
        L_shlOutVar1     = acc_q;
        L_shlNumShiftOut = 16'(SHIFT);
        L_shlReady       = !shlIss_q;
        if (L_shlDone) begin
          yVal_d  = L_shlIn[31:16];
          state_d = WR;
        end
      end
      WR: begin
        memWriteAddr = yWr;
        memOut       = {{16{yVal_q[15]}}, yVal_q};
        memWriteEn   = 1'b1;
        if (lastSample) begin
          state_d = FIN;
        end else begin
          incN    = 1'b1;
          state_d = CLR;
        end
      end
      FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CONV_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // holds in IDLE; cleared by the start that leaves IDLE
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (start) cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycleCount = cnt_q;
`endif

endmodule

// File: tb/tb_convolve_ctrl.sv
// Directed bench for convolve_ctrl: two instances (L=40, L=1) with
// behavioural scratch memory, L_mac and L_shl models.
module tb_convolve_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int shlWait = 0;

  logic        start0, start1;
  logic [10:0] xAddr0, hAddr0, yAddr0, xAddr1, hAddr1, yAddr1;
  logic [31:0] memIn0, memIn1, L_macIn0, L_macIn1, L_shlIn0, L_shlIn1;
  logic        L_shlDone0, L_shlDone1;
  logic [10:0] memWriteAddr0, memWriteAddr1;
  logic        memWriteEn0, memWriteEn1;
  logic [31:0] memOut0, memOut1;
  logic [15:0] L_macOutA0, L_macOutB0, L_macOutA1, L_macOutB1;
  logic [31:0] L_macOutC0, L_macOutC1, L_shlOutVar10, L_shlOutVar11;
  logic [15:0] L_shlNumShiftOut0, L_shlNumShiftOut1;
  logic        L_shlReady0, L_shlReady1;
  logic        lagMuxSel0, lagMux1Sel0, lagMuxSel1, lagMux1Sel1;
  logic        busy0, busy1, done0, done1;
`ifdef CONV_CYCLE_CNT_EN
  logic [15:0] cycleCount0, cycleCount1;
`endif

  logic [10:0] tpAddr0 = '0, tpAddr1 = '0;
  logic [31:0] tpData0 = '0, tpData1 = '0;
  logic        tpWe0 = 1'b0, tpWe1 = 1'b0;
  logic [31:0] mem0 [2048];
  logic [31:0] mem1 [2048];
  logic [3:0]  shlCnt0 = '0, shlCnt1 = '0;
  int wrCnt0 = 0, wrCnt1 = 0, doneCnt0 = 0, rdyCnt0 = 0;

  convolve_ctrl #(.L(40)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .xAddr(xAddr0), .hAddr(hAddr0), .yAddr(yAddr0),
    .memIn(memIn0), .L_macIn(L_macIn0), .L_shlIn(L_shlIn0),
    .L_shlDone(L_shlDone0), .memWriteAddr(memWriteAddr0),
    .memWriteEn(memWriteEn0), .memOut(memOut0),
    .L_macOutA(L_macOutA0), .L_macOutB(L_macOutB0),
    .L_macOutC(L_macOutC0), .L_shlOutVar1(L_shlOutVar10),
    .L_shlNumShiftOut(L_shlNumShiftOut0), .L_shlReady(L_shlReady0),
    .lagMuxSel(lagMuxSel0), .lagMux1Sel(lagMux1Sel0),
    .busy(busy0), .done(done0)
`ifdef CONV_CYCLE_CNT_EN
    , .cycleCount(cycleCount0)
`endif
  );

  convolve_ctrl #(.L(1)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .xAddr(xAddr1), .hAddr(hAddr1), .yAddr(yAddr1),
    .memIn(memIn1), .L_macIn(L_macIn1), .L_shlIn(L_shlIn1),
    .L_shlDone(L_shlDone1), .memWriteAddr(memWriteAddr1),
    .memWriteEn(memWriteEn1), .memOut(memOut1),
    .L_macOutA(L_macOutA1), .L_macOutB(L_macOutB1),
    .L_macOutC(L_macOutC1), .L_shlOutVar1(L_shlOutVar11),
    .L_shlNumShiftOut(L_shlNumShiftOut1), .L_shlReady(L_shlReady1),
    .lagMuxSel(lagMuxSel1), .lagMux1Sel(lagMux1Sel1),
    .busy(busy1), .done(done1)
`ifdef CONV_CYCLE_CNT_EN
    , .cycleCount(cycleCount1)
`endif
  );

  function automatic logic [31:0] sat32(input longint s);
    if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (s < -64'sh80000000) return 32'h80000000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] lmac(input logic [15:0] a, b,
                                       input logic [31:0] c);
    longint p;
    if (a == 16'h8000 && b == 16'h8000) p = 64'sh7FFFFFFF;
    else p = 2 * longint'($signed(a)) * longint'($signed(b));
    return sat32(longint'($signed(c)) + p);
  endfunction

  function automatic logic [31:0] lshl(input logic [31:0] v,
                                       input logic [15:0] n);
    return sat32(longint'($signed(v)) <<< n[4:0]);
  endfunction

  always_comb begin
    L_macIn0 = lmac(L_macOutA0, L_macOutB0, L_macOutC0);
    L_macIn1 = lmac(L_macOutA1, L_macOutB1, L_macOutC1);
    L_shlIn0 = lshl(L_shlOutVar10, L_shlNumShiftOut0);
    L_shlIn1 = lshl(L_shlOutVar11, L_shlNumShiftOut1);
    L_shlDone0 = (shlWait == 0) ? L_shlReady0 : (shlCnt0 == 4'd1);
    L_shlDone1 = (shlWait == 0) ? L_shlReady1 : (shlCnt1 == 4'd1);
  end

  always @(posedge clk) begin
    memIn0 <= mem0[lagMuxSel0 ? tpAddr0 : memWriteAddr0];
    memIn1 <= mem1[lagMuxSel1 ? tpAddr1 : memWriteAddr1];
    if (lagMux1Sel0 ? tpWe0 : memWriteEn0)
      mem0[lagMux1Sel0 ? tpAddr0 : memWriteAddr0] <=
        lagMux1Sel0 ? tpData0 : memOut0;
    if (lagMux1Sel1 ? tpWe1 : memWriteEn1)
      mem1[lagMux1Sel1 ? tpAddr1 : memWriteAddr1] <=
        lagMux1Sel1 ? tpData1 : memOut1;
    if (L_shlReady0) shlCnt0 <= 4'(shlWait);
    else if (shlCnt0 != 0) shlCnt0 <= shlCnt0 - 1'b1;
    if (L_shlReady1) shlCnt1 <= 4'(shlWait);
    else if (shlCnt1 != 0) shlCnt1 <= shlCnt1 - 1'b1;
    if (memWriteEn0) wrCnt0 <= wrCnt0 + 1;
    if (memWriteEn1) wrCnt1 <= wrCnt1 + 1;
    if (done0) doneCnt0 <= doneCnt0 + 1;
    if (L_shlReady0) rdyCnt0 <= rdyCnt0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tpw0(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    tpAddr0 = a; tpData0 = d; tpWe0 = 1'b1;
    @(negedge clk);
    tpWe0 = 1'b0;
  endtask

  task automatic tpw1(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    tpAddr1 = a; tpData1 = d; tpWe1 = 1'b1;
    @(negedge clk);
    tpWe1 = 1'b0;
  endtask

  task automatic tpr0(input logic [10:0] a, output logic [31:0] d);
    @(negedge clk);
    tpAddr0 = a;
    @(negedge clk);
    d = memIn0;
  endtask

  task automatic tpr1(input logic [10:0] a, output logic [31:0] d);
    @(negedge clk);
    tpAddr1 = a;
    @(negedge clk);
    d = memIn1;
  endtask

  task automatic go0(input logic [10:0] xa, ha, ya, input bit poke,
                     output int cyc);
    @(negedge clk);
    xAddr0 = xa; hAddr0 = ha; yAddr0 = ya; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    if (poke) begin
      xAddr0 = '1; hAddr0 = '1; yAddr0 = '1;
    end
    cyc = 1;
    while (!done0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10)
        chk("busy_sel", {29'd0, busy0, lagMuxSel0, lagMux1Sel0}, 32'd4);
      start0 = poke && (cyc == 50 || cyc == 100);
    end
    start0 = 1'b0;
  endtask

  task automatic go1(input logic [10:0] xa, ha, ya, output int cyc);
    @(negedge clk);
    xAddr1 = xa; hAddr1 = ha; yAddr1 = ya; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
`ifdef CONV_CYCLE_CNT_EN
    chk("cnt_clr", {16'd0, cycleCount1}, 32'd0);
`endif
    cyc = 1;
    while (!done1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_impulse();
    for (int k = 0; k < 40; k++) begin
      tpw0(11'(k), (k == 0) ? 32'h1000 : 32'h0);
      tpw0(11'(200 + k), 32'(k + 1));
    end
  endtask

  task automatic check_y0(input string tag, input int base,
                          input logic [31:0] sat);
    logic [31:0] d;
    for (int k = 0; k < 40; k++) begin
      tpr0(11'(base + k), d);
      chk(tag, d, (sat != 0) ? sat : 32'(k + 1));
    end
  endtask

  initial begin
    int cyc, w0, d0, r0, k;
    logic [31:0] d;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    xAddr0 = '0; hAddr0 = '0; yAddr0 = '0;
    xAddr1 = '0; hAddr1 = '0; yAddr1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel", {30'd0, lagMuxSel0, lagMux1Sel0}, 32'd3);
    chk("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
    chk("rst_wr", {20'd0, memWriteEn0, memWriteAddr0}, 32'd0);
    chk("rst_mac", {L_macOutA0, L_macOutB0} | L_macOutC0, 32'd0);
    chk("rst_shl", {15'd0, L_shlReady0, L_shlNumShiftOut0}
                   | L_shlOutVar10 | memOut0, 32'd0);
`ifdef CONV_CYCLE_CNT_EN
    chk("rst_cnt", {16'd0, cycleCount0}, 32'd0);
`endif
    start0 = 1'b1;
    @(negedge clk);
    chk("start_in_reset", {31'd0, busy0}, 32'd0);
    start0 = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {30'd0, busy0, lagMuxSel0}, 32'd1);

    tpw0(11'd100, 32'hA5A51234);
    tpr0(11'd100, d);
    chk("tp_write", d, 32'hA5A51234);

    // impulse, L=40
    load_impulse();
    tpw0(11'd440, 32'hDEADBEEF);
    w0 = wrCnt0; d0 = doneCnt0; r0 = rdyCnt0;
    go0(11'd0, 11'd200, 11'd400, 1'b0, cyc);
    chk("imp_cycles", cyc, 32'd2581);
    @(negedge clk);
    chk("imp_writes", wrCnt0 - w0, 32'd40);
    chk("imp_rdy", rdyCnt0 - r0, 32'd40);
    chk("imp_done", doneCnt0 - d0, 32'd1);
    check_y0("imp_y", 400, 32'd0);
    tpr0(11'd440, d);
    chk("imp_sentinel", d, 32'hDEADBEEF);

    // start pulses and base changes while busy are ignored
    d0 = doneCnt0; w0 = wrCnt0;
    go0(11'd0, 11'd200, 11'd800, 1'b1, cyc);
    chk("poke_cycles", cyc, 32'd2581);
    repeat (20) @(negedge clk);
    chk("poke_done", doneCnt0 - d0, 32'd1);
    chk("poke_writes", wrCnt0 - w0, 32'd40);
    check_y0("poke_y", 800, 32'd0);

    // saturation with a 2-cycle L_shl wait
    for (int j = 0; j < 40; j++) begin
      tpw0(11'(j), 32'h7FFF);
      tpw0(11'(200 + j), 32'h7FFF);
    end
    shlWait = 2;
    r0 = rdyCnt0;
    go0(11'd0, 11'd200, 11'd500, 1'b0, cyc);
    chk("sat_cycles", cyc, 32'd2661);
    chk("sat_rdy", rdyCnt0 - r0, 32'd40);
    check_y0("sat_y", 500, 32'h00007FFF);
    shlWait = 0;

    // reset in the middle of sample n=5
    load_impulse();
    w0 = wrCnt0;
    @(negedge clk);
    xAddr0 = 11'd0; hAddr0 = 11'd200; yAddr0 = 11'd600; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (wrCnt0 - w0 < 5 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", {29'd0, busy0, lagMuxSel0, lagMux1Sel0}, 32'd3);
    chk("mid_rst_wr", {19'd0, done0, memWriteEn0, memWriteAddr0}, 32'd0);
    chk("mid_rst_shl", {31'd0, L_shlReady0} | L_macOutC0, 32'd0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_rst_nowr", wrCnt0 - w0, 32'd5);
    tpr0(11'd604, d);
    chk("mid_rst_y4", d, 32'd5);
    go0(11'd0, 11'd200, 11'd700, 1'b0, cyc);
    chk("restart_cycles", cyc, 32'd2581);
    check_y0("restart_y", 700, 32'd0);

    // single product, L=1
    tpw1(11'd0, 32'h1000);
    tpw1(11'd10, 32'h0800);
    tpw1(11'd21, 32'hCAFEF00D);
    w0 = wrCnt1;
    go1(11'd0, 11'd10, 11'd20, cyc);
    chk("one_cycles", cyc, 32'd7);
    @(negedge clk);
`ifdef CONV_CYCLE_CNT_EN
    chk("cnt_one", {16'd0, cycleCount1}, 32'd7);
`endif
    chk("one_writes", wrCnt1 - w0, 32'd1);
    tpr1(11'd20, d);
    chk("one_y", d, 32'h00000800);
    tpr1(11'd21, d);
    chk("one_sentinel", d, 32'hCAFEF00D);

    // negative saturation, upper operand bits ignored
    tpw1(11'd0, 32'h12348000);
    tpw1(11'd10, 32'hABCD7FFF);
    go1(11'd0, 11'd10, 11'd30, cyc);
    chk("neg_cycles", cyc, 32'd7);
    @(negedge clk);
`ifdef CONV_CYCLE_CNT_EN
    chk("cnt_two", {16'd0, cycleCount1}, 32'd7);
`endif
    tpr1(11'd30, d);
    chk("neg_y", d, 32'hFFFF8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
